// File: rtl/downsizing_pkg.sv
// Shared constants and helpers for the downsizing block: legal ratio range,
// lane-index width and the tkeep legality check used by DOWNSIZING_TKEEP_EN builds.
package downsizing_pkg;

    localparam int R_MIN = 2;
    localparam int R_MAX = 8;

    function automatic int idx_width(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

    // Legal keep: lane r-1 kept and no kept lane below a dropped one.
    function automatic logic keep_legal(input logic [R_MAX-1:0] keep, input int r);
        logic legal;
        logic seen_zero;
        legal     = keep[r-1];
        seen_zero = 1'b0;
        for (int i = R_MAX - 1; i >= 0; i--) begin
            if (i < r) begin
                if (!keep[i]) begin
                    seen_zero = 1'b1;
                end else if (seen_zero) begin
                    legal = 1'b0;
                end
            end
        end
        return legal;
    endfunction

endpackage

// File: rtl/downsizing.sv
// Wide-to-narrow stream downsizer: one W*R holding register, emitted lane R-1 first.
// Optional macro DOWNSIZING_TKEEP_EN adds in_tkeep to emit only the kept upper lanes.
module downsizing
    import downsizing_pkg::*;
#(
    parameter int W = 40,
    parameter int R = 2
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [W*R-1:0] in_tdata,
    input  logic           in_tvalid,
    input  logic           in_tlast,
`ifdef DOWNSIZING_TKEEP_EN
    input  logic [R-1:0]   in_tkeep,
`endif
    output logic           in_tready,
    output logic [W-1:0]   out_tdata,
    output logic           out_tvalid,
    output logic           out_tlast,
    input  logic           out_tready
);

    localparam int             IW      = idx_width(R);
    localparam logic [IW-1:0]  IDX_TOP = IW'(R - 1);

    generate
        if (R < R_MIN || R > R_MAX) begin : g_bad_ratio
            $error("downsizing: parameter R outside legal range");
        end
    endgenerate

    logic [W*R-1:0] data_q, data_d;
    logic           last_q, last_d;
    logic           full_q, full_d;
    logic [IW-1:0]  idx_q,  idx_d;
`ifdef DOWNSIZING_TKEEP_EN
    logic [R-1:0]   keep_q, keep_d;
`endif

    logic [IW-1:0]  low_idx;
    logic           at_low;
    logic           in_fire;
    logic           out_fire;
    logic [W-1:0]   out_data;

    // Lowest lane of the held word that will be emitted; the word is released there.
    always_comb begin
`ifdef DOWNSIZING_TKEEP_EN
        low_idx = IDX_TOP;
        for (int k = R - 1; k >= 0; k--) begin
            if (keep_q[k]) begin
                low_idx = IW'(k);
            end
        end
`else
        low_idx = '0;
`endif
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < R; k++) begin
            if (idx_q == IW'(k)) begin
                out_data = data_q[k*W +: W];
            end
        end
    end

    assign at_low     = (idx_q == low_idx);
    assign in_tready  = !areset && (!full_q || (out_tready && at_low));
    assign in_fire    = in_tvalid && in_tready;
    assign out_fire   = full_q && out_tready;
    assign out_tvalid = full_q;
    assign out_tdata  = out_data;
    assign out_tlast  = full_q && last_q && at_low;

    always_comb begin
        data_d = data_q;
        last_d = last_q;
        full_d = full_q;
        idx_d  = idx_q;
`ifdef DOWNSIZING_TKEEP_EN
        keep_d = keep_q;
`endif
        // A new word may be loaded in the same cycle the last lane leaves.
        if (in_fire) begin
            data_d = in_tdata;
            last_d = in_tlast;
            full_d = 1'b1;
            idx_d  = IDX_TOP;
`ifdef DOWNSIZING_TKEEP_EN
            keep_d = in_tkeep;
`endif
        end else if (out_fire) begin
            if (at_low) begin
                full_d = 1'b0;
                idx_d  = IDX_TOP;
            end else begin
                idx_d  = idx_q - IW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            full_q <= 1'b0;
            idx_q  <= IDX_TOP;
        end else begin
            full_q <= full_d;
            idx_q  <= idx_d;
        end
    end

    // Payload flops carry no reset; full_q alone says whether they mean anything.
    always_ff @(posedge aclk) begin
        data_q <= data_d;
        last_q <= last_d;
`ifdef DOWNSIZING_TKEEP_EN
        keep_q <= keep_d;
`endif
    end

    a_valid_stable: assert property (@(posedge aclk) disable iff (areset)
        (out_tvalid && !out_tready) |=> out_tvalid);

    a_idx_idle: assert property (@(posedge aclk) disable iff (areset)
        !full_q |-> (idx_q == IDX_TOP));

`ifdef DOWNSIZING_TKEEP_EN
    a_keep_legal: assert property (@(posedge aclk) disable iff (areset)
        in_fire |-> keep_legal(R_MAX'(in_tkeep), R));
`endif

endmodule

// File: tb/tb_downsizing.sv
// Self-checking bench for downsizing: directed R=2 and R=4 scenarios plus a random
// valid/ready run, all checked against a lane-order scoreboard fed at input acceptance.
module tb_downsizing;

    localparam int W  = 40;
    localparam int RA = 2;
    localparam int RB = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;

    logic [W*RA-1:0] a_in_tdata = '0;
    logic            a_in_tvalid = 1'b0;
    logic            a_in_tlast = 1'b0;
    logic            a_in_tready;
    logic [W-1:0]    a_out_tdata;
    logic            a_out_tvalid;
    logic            a_out_tlast;
    logic            a_out_tready = 1'b0;

    logic [W*RB-1:0] b_in_tdata = '0;
    logic            b_in_tvalid = 1'b0;
    logic            b_in_tlast = 1'b0;
    logic            b_in_tready;
    logic [W-1:0]    b_out_tdata;
    logic            b_out_tvalid;
    logic            b_out_tlast;
    logic            b_out_tready = 1'b0;
`ifdef DOWNSIZING_TKEEP_EN
    logic [RB-1:0]   b_in_tkeep = '1;
    logic [RA-1:0]   a_in_tkeep = '1;
`endif

    beat_t qa[$];
    beat_t qb[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    downsizing #(.W(W), .R(RA)) dut_a (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (a_in_tdata),
        .in_tvalid  (a_in_tvalid),
        .in_tlast   (a_in_tlast),
`ifdef DOWNSIZING_TKEEP_EN
        .in_tkeep   (a_in_tkeep),
`endif
        .in_tready  (a_in_tready),
        .out_tdata  (a_out_tdata),
        .out_tvalid (a_out_tvalid),
        .out_tlast  (a_out_tlast),
        .out_tready (a_out_tready)
    );

    downsizing #(.W(W), .R(RB)) dut_b (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (b_in_tdata),
        .in_tvalid  (b_in_tvalid),
        .in_tlast   (b_in_tlast),
`ifdef DOWNSIZING_TKEEP_EN
        .in_tkeep   (b_in_tkeep),
`endif
        .in_tready  (b_in_tready),
        .out_tdata  (b_out_tdata),
        .out_tvalid (b_out_tvalid),
        .out_tlast  (b_out_tlast),
        .out_tready (b_out_tready)
    );

    // Scoreboard feed: every accepted wide word becomes its narrow lanes, MSB lane first.
    always @(posedge aclk) begin
        beat_t e;
        if (a_in_tvalid && a_in_tready) begin
            for (int k = RA - 1; k >= 0; k--) begin
                e.data = a_in_tdata[k*W +: W];
                e.last = a_in_tlast && (k == 0);
                qa.push_back(e);
            end
        end
    end

    always @(posedge aclk) begin
        beat_t e;
        logic [RB-1:0] keep;
        int low;
`ifdef DOWNSIZING_TKEEP_EN
        keep = b_in_tkeep;
`else
        keep = '1;
`endif
        if (b_in_tvalid && b_in_tready) begin
            low = RB - 1;
            for (int k = RB - 1; k >= 0; k--) begin
                if (keep[k]) low = k;
            end
            for (int k = RB - 1; k >= low; k--) begin
                e.data = b_in_tdata[k*W +: W];
                e.last = b_in_tlast && (k == low);
                qb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [255:0] rand_bits();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        repeat (2) step();
        n_checks++;
        if (a_in_tready !== 1'b0 || b_in_tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready_low: got a=%b b=%b expected 0", a_in_tready, b_in_tready);
        end
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (a_out_tvalid !== 1'b0 || a_out_tlast !== 1'b0 || a_in_tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_state_a: got valid=%b last=%b ready=%b expected 0 0 1",
                     a_out_tvalid, a_out_tlast, a_in_tready);
        end
        n_checks++;
        if (b_out_tvalid !== 1'b0 || b_out_tlast !== 1'b0 || b_in_tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_state_b: got valid=%b last=%b ready=%b expected 0 0 1",
                     b_out_tvalid, b_out_tlast, b_in_tready);
        end
        step();
    endtask

    task automatic test_single_word();
        a_out_tready = 1'b1;
        a_in_tdata   = 80'hAAAAAAAAAA_5555555555;
        a_in_tlast   = 1'b1;
        a_in_tvalid  = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (a_in_tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_accept: got ready=%b expected 1", a_in_tready);
        end
        step();
        a_in_tvalid = 1'b0;
        a_in_tlast  = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (a_out_tvalid !== 1'b1 || a_out_tdata !== 40'hAAAAAAAAAA || a_out_tlast !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_lane1: got v=%b d=%h l=%b expected 1 aaaaaaaaaa 0",
                     a_out_tvalid, a_out_tdata, a_out_tlast);
        end
        step();
        @(negedge aclk);
        n_checks++;
        if (a_out_tvalid !== 1'b1 || a_out_tdata !== 40'h5555555555 || a_out_tlast !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_lane0: got v=%b d=%h l=%b expected 1 5555555555 1",
                     a_out_tvalid, a_out_tdata, a_out_tlast);
        end
        step();
        @(negedge aclk);
        n_checks++;
        if (a_out_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_idle: got valid=%b expected 0", a_out_tvalid);
        end
        qa.delete();
        step();
    endtask

    task automatic test_back_to_back();
        logic [W*RA-1:0] words [8];
        logic [255:0] r;
        beat_t e;
        logic acc;
        logic exp_rdy;
        int sent, got, first_out, last_out;
        for (int i = 0; i < 8; i++) begin
            r = rand_bits();
            words[i] = r[W*RA-1:0];
        end
        sent = 0; got = 0; first_out = -1; last_out = -1; exp_rdy = 1'b1;
        a_out_tready = 1'b1;
        a_in_tdata   = words[0];
        a_in_tlast   = 1'b0;
        a_in_tvalid  = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            @(negedge aclk);
            if (a_in_tvalid) begin
                n_checks++;
                if (a_in_tready !== exp_rdy) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_ready cyc%0d: got %b expected %b", cyc, a_in_tready, exp_rdy);
                end
                exp_rdy = !exp_rdy;
            end
            if (a_out_tvalid && a_out_tready) begin
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_extra: got d=%h expected no output", a_out_tdata);
                end else begin
                    e = qa.pop_front();
                    if (a_out_tdata !== e.data || a_out_tlast !== e.last) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_data: got d=%h l=%b expected d=%h l=%b",
                                 a_out_tdata, a_out_tlast, e.data, e.last);
                    end
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            acc = a_in_tvalid && a_in_tready;
            step();
            if (acc) begin
                sent++;
                if (sent == 8) begin
                    a_in_tvalid = 1'b0;
                end else begin
                    a_in_tdata = words[sent];
                end
                a_in_tlast = (sent == 7);
            end
        end
        a_in_tvalid = 1'b0;
        n_checks++;
        if (got !== 16 || (last_out - first_out) !== 15) begin
            n_fail++;
            $display("[TB] FAIL b2b_rate: got %0d words over span %0d expected 16 over 15",
                     got, last_out - first_out);
        end
    endtask

    task automatic test_stall();
        beat_t e;
        logic acc;
        int got;
        a_out_tready = 1'b1;
        a_in_tdata   = 80'h1111111111_2222222222;
        a_in_tlast   = 1'b0;
        a_in_tvalid  = 1'b1;
        @(negedge aclk);
        step();
        a_in_tdata = 80'h3333333333_4444444444;
        a_in_tlast = 1'b1;
        @(negedge aclk);
        n_checks++;
        e = qa.pop_front();
        if (a_out_tvalid !== 1'b1 || a_out_tdata !== e.data || a_out_tlast !== e.last) begin
            n_fail++;
            $display("[TB] FAIL stall_first: got v=%b d=%h expected 1 %h", a_out_tvalid, a_out_tdata, e.data);
        end
        step();
        a_out_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            n_checks++;
            if (a_out_tvalid !== 1'b1 || a_out_tdata !== 40'h2222222222 ||
                a_out_tlast !== 1'b0 || a_in_tready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_hold%0d: got v=%b d=%h l=%b rdy=%b expected 1 2222222222 0 0",
                         i, a_out_tvalid, a_out_tdata, a_out_tlast, a_in_tready);
            end
            step();
        end
        a_out_tready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge aclk);
            if (a_out_tvalid && a_out_tready) begin
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL stall_extra: got d=%h expected no output", a_out_tdata);
                end else begin
                    e = qa.pop_front();
                    if (a_out_tdata !== e.data || a_out_tlast !== e.last) begin
                        n_fail++;
                        $display("[TB] FAIL stall_resume: got d=%h l=%b expected d=%h l=%b",
                                 a_out_tdata, a_out_tlast, e.data, e.last);
                    end
                end
                got++;
            end
            acc = a_in_tvalid && a_in_tready;
            step();
            if (acc) a_in_tvalid = 1'b0;
        end
        a_in_tvalid = 1'b0;
        n_checks++;
        if (got !== 3 || qa.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL stall_count: got %0d words, %0d pending expected 3, 0", got, qa.size());
        end
    endtask

    task automatic test_random();
        beat_t e;
        logic acc;
        logic [255:0] r;
        int sent, got;
        sent = 0; got = 0;
        a_in_tvalid = 1'b0;
        for (int cyc = 0; cyc < 20000 && got < 400; cyc++) begin
            @(negedge aclk);
            if (a_out_tvalid && a_out_tready) begin
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rand_extra: got d=%h expected no output", a_out_tdata);
                end else begin
                    e = qa.pop_front();
                    if (a_out_tdata !== e.data || a_out_tlast !== e.last) begin
                        n_fail++;
                        $display("[TB] FAIL rand_data: got d=%h l=%b expected d=%h l=%b",
                                 a_out_tdata, a_out_tlast, e.data, e.last);
                    end
                end
                got++;
            end
            acc = a_in_tvalid && a_in_tready;
            step();
            if (acc) sent++;
            if (acc || !a_in_tvalid) begin
                if (sent < 200 && $urandom_range(0, 3) != 0) begin
                    r = rand_bits();
                    a_in_tdata  = r[W*RA-1:0];
                    a_in_tlast  = r[200];
                    a_in_tvalid = 1'b1;
                end else begin
                    a_in_tvalid = 1'b0;
                end
            end
            a_out_tready = ($urandom_range(0, 2) != 0);
        end
        a_in_tvalid = 1'b0;
        a_out_tready = 1'b1;
        n_checks++;
        if (got !== 400 || qa.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL rand_count: got %0d words, %0d pending expected 400, 0", got, qa.size());
        end
    endtask

    task automatic test_reset_mid_word();
        beat_t e;
        logic acc;
        int got;
        b_out_tready = 1'b1;
        b_in_tdata   = 160'hCAFEBABE01_0123456789_DEADBEEF02_1357924680;
        b_in_tlast   = 1'b1;
        b_in_tvalid  = 1'b1;
        @(negedge aclk);
        step();
        b_in_tvalid = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (b_out_tvalid !== 1'b1 || b_out_tdata !== 40'hCAFEBABE01) begin
            n_fail++;
            $display("[TB] FAIL rst_lane3: got v=%b d=%h expected 1 cafebabe01", b_out_tvalid, b_out_tdata);
        end
        step();
        areset = 1'b1;
        b_out_tready = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (b_in_tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_ready_low: got %b expected 0", b_in_tready);
        end
        step();
        areset = 1'b0;
        b_out_tready = 1'b1;
        qb.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            n_checks++;
            if (b_out_tvalid !== 1'b0 || b_in_tready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL rst_discard%0d: got v=%b rdy=%b expected 0 1", i, b_out_tvalid, b_in_tready);
            end
            step();
        end
        b_in_tdata  = 160'h00000000A3_00000000A2_00000000A1_00000000A0;
        b_in_tlast  = 1'b0;
        b_in_tvalid = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge aclk);
            if (b_out_tvalid && b_out_tready) begin
                n_checks++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rst_extra: got d=%h expected no output", b_out_tdata);
                end else begin
                    e = qb.pop_front();
                    if (b_out_tdata !== e.data || b_out_tlast !== e.last) begin
                        n_fail++;
                        $display("[TB] FAIL rst_next_word: got d=%h l=%b expected d=%h l=%b",
                                 b_out_tdata, b_out_tlast, e.data, e.last);
                    end
                end
                got++;
            end
            acc = b_in_tvalid && b_in_tready;
            step();
            if (acc) b_in_tvalid = 1'b0;
        end
        b_in_tvalid = 1'b0;
        n_checks++;
        if (got !== 4 || qb.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL rst_count: got %0d words, %0d pending expected 4, 0", got, qb.size());
        end
    endtask

`ifdef DOWNSIZING_TKEEP_EN
    task automatic test_tkeep();
        beat_t e;
        logic acc;
        int got;
        b_out_tready = 1'b1;
        b_in_tdata   = 160'h00000000B3_00000000B2_00000000B1_00000000B0;
        b_in_tkeep   = 4'b1100;
        b_in_tlast   = 1'b1;
        b_in_tvalid  = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge aclk);
            if (b_out_tvalid && b_out_tready) begin
                n_checks++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL keep_extra: got d=%h expected no output", b_out_tdata);
                end else begin
                    e = qb.pop_front();
                    if (b_out_tdata !== e.data || b_out_tlast !== e.last) begin
                        n_fail++;
                        $display("[TB] FAIL keep_data: got d=%h l=%b expected d=%h l=%b",
                                 b_out_tdata, b_out_tlast, e.data, e.last);
                    end
                end
                got++;
            end
            acc = b_in_tvalid && b_in_tready;
            step();
            if (acc) begin
                b_in_tvalid = 1'b0;
                b_in_tkeep  = '1;
            end
        end
        n_checks++;
        if (got !== 2) begin
            n_fail++;
            $display("[TB] FAIL keep_count: got %0d words expected 2", got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid_word();
`ifdef DOWNSIZING_TKEEP_EN
        test_tkeep();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
